// File: rtl/seq_alu_pipe.sv
// seq_alu_pipe -- handshaked sequential ALU placed between operand fetch and
// writeback. Add, sub, xor and set-less-than finish one cycle after accept.
// Shifts move the working register one bit per cycle, so no barrel shifter
// is needed at any WIDTH. Only one operation is in flight at a time.
//
// Build option: define SEQ_ALU_SRA_EN to make opcode 111 an arithmetic
// shift right. Without it, 111 is an undefined op (out=0, zero=1).
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; discards any in-flight op
//   in_valid  busA/busB/ctrl valid         in_ready  block can accept an op
//   busA      operand A                    busB      operand B / shift amount
//   ctrl      opcode (000 add, 001 sub, 010 xor, 011 slt, 101 sll, 110 srl,
//             111 sra when enabled)
//   out_valid result and flags valid       out_ready consumer takes result
//   out       result                       zero      out == 0
//   ovf       signed overflow (add/sub)    carry     carry-out (add/sub)
module seq_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             carry
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // SHIFT is the busy state for every op: single-cycle ops pass through it
  // once with cnt=0, shifts stay for cnt cycles and then finalize.
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     work;     // operand A; shifted in place for shift ops
  logic [WIDTH-1:0]     work_nxt;
  logic [WIDTH-1:0]     b_q;
  logic [SHAMT_W-1:0]   cnt;
  logic                 accept;

  logic [WIDTH:0]       sum, diff;
  logic                 add_ovf, sub_ovf;
  logic [WIDTH-1:0]     res;
  logic                 res_v, res_c;

  function automatic logic is_shift(input logic [2:0] op);
    case (op)
      OP_SLL, OP_SRL: is_shift = 1'b1;
`ifdef SEQ_ALU_SRA_EN
      OP_SRA:         is_shift = 1'b1;
`endif
      default:        is_shift = 1'b0;
    endcase
  endfunction

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One-bit step in the direction of the latched shift op.
  always_comb begin
    work_nxt = work;
    case (op_q)
      OP_SLL:  work_nxt = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_nxt = {1'b0, work[WIDTH-1:1]};
`ifdef SEQ_ALU_SRA_EN
      OP_SRA:  work_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
`endif
      default: work_nxt = work;
    endcase
  end

  // Arithmetic on the latched operands; subtraction is A + ~B + 1 so its
  // carry-out is 1 when no borrow occurs.
  assign sum     = {1'b0, work} + {1'b0, b_q};
  assign diff    = {1'b0, work} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (work[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1]  != work[WIDTH-1]);
  assign sub_ovf = (work[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != work[WIDTH-1]);

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = add_ovf;
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = sub_ovf;
      end
      OP_XOR:         res = work ^ b_q;
      OP_SLT:         res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_SLL, OP_SRL: res = work;
`ifdef SEQ_ALU_SRA_EN
      OP_SRA:         res = work;
`endif
      default:        res = '0;
    endcase
  end

  // Control counter and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      out   <= '0;
      zero  <= 1'b1;
      ovf   <= 1'b0;
      carry <= 1'b0;
    end else if (accept) begin
      cnt <= is_shift(ctrl) ? busB[SHAMT_W-1:0] : '0;
    end else if (state == S_SHIFT) begin
      if (cnt != '0) begin
        cnt <= cnt - SHAMT_W'(1);
      end else begin
        out   <= res;
        zero  <= (res == '0);
        ovf   <= res_v;
        carry <= res_c;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are always reloaded on
  // accept before being read, so resetting them would only cost wiring.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= ctrl;
      work <= busA;
      b_q  <= busB;
    end else if (state == S_SHIFT && cnt != '0) begin
      work <= work_nxt;
    end
  end

endmodule
